// File: rtl/mux_rr_sched.sv
// Round-robin scheduler: arbitrates eight requesters onto one 4-bit selector and
// streams the granted requester's words to a valid/ready consumer in bursts.

module mux_rr_sched_sel (
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  input  logic [3:0] in3,
  input  logic [3:0] in4,
  input  logic [3:0] in5,
  input  logic [3:0] in6,
  input  logic [3:0] in7,
  input  logic [3:0] in8,
  input  logic [2:0] sel,
  output logic [3:0] out
);

  // 8-way, 4-bit selector
  always_comb begin
    out = in1;
    case (sel)
      3'd0: out = in1;
      3'd1: out = in2;
      3'd2: out = in3;
      3'd3: out = in4;
      3'd4: out = in5;
      3'd5: out = in6;
      3'd6: out = in7;
      3'd7: out = in8;
      default: out = in1;
    endcase
  end

endmodule

module mux_rr_sched #(
  parameter int unsigned BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  input  logic [3:0] in3,
  input  logic [3:0] in4,
  input  logic [3:0] in5,
  input  logic [3:0] in6,
  input  logic [3:0] in7,
  input  logic [3:0] in8,
  input  logic       out_ready,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic [3:0] out,
  output logic       out_valid,
  output logic       busy
);

  localparam int unsigned NREQ = 8;
  localparam int unsigned SELW = 3;
  localparam int unsigned DW   = 4;
  localparam int unsigned CNTW = 5;

  typedef enum logic {IDLE, XFER} state_t;

  state_t            state, state_nxt;
  logic [SELW-1:0]   ptr, ptr_nxt;
  logic [SELW-1:0]   sel_nxt;
  logic [NREQ-1:0]   gnt_nxt;
  logic [CNTW-1:0]   beat_cnt, beat_cnt_nxt;

  logic [SELW-1:0]   pick;
  logic              pick_vld;
  logic [DW-1:0]     mux_out;
  logic              accept;
  logic              last_beat;
  logic              withdraw;

  mux_rr_sched_sel u_sel (
    .in1 (in1),
    .in2 (in2),
    .in3 (in3),
    .in4 (in4),
    .in5 (in5),
    .in6 (in6),
    .in7 (in7),
    .in8 (in8),
    .sel (sel),
    .out (mux_out)
  );

  // Rotating-priority pick: scan from the far end so the lowest offset from ptr wins
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (req[SELW'(ptr + SELW'(i))]) begin
        pick     = SELW'(ptr + SELW'(i));
        pick_vld = 1'b1;
      end
    end
  end

  assign accept    = out_valid & out_ready;
  assign last_beat = accept && (beat_cnt == CNTW'(BURST - 1));
  assign withdraw  = (state == XFER) && !req[sel];

  // State and grant registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      sel      <= '0;
      gnt      <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      sel      <= sel_nxt;
      gnt      <= gnt_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    sel_nxt      = sel;
    gnt_nxt      = gnt;
    beat_cnt_nxt = beat_cnt;
    case (state)
      IDLE: begin
        gnt_nxt = '0;
        if (pick_vld) begin
          state_nxt    = XFER;
          sel_nxt      = pick;
          gnt_nxt      = NREQ'(1) << pick;
          beat_cnt_nxt = '0;
        end
      end
      XFER: begin
        // withdrawal and last beat both hand priority to the next requester
        if (withdraw || last_beat) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          ptr_nxt   = sel + SELW'(1);
        end else if (accept) begin
          beat_cnt_nxt = beat_cnt + CNTW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  // Output logic: valid follows the granted request line without a pipeline stage
  always_comb begin
    busy      = (state == XFER);
    out_valid = busy & req[sel];
    out       = out_valid ? mux_out : '0;
  end

endmodule

// File: tb/tb_mux_rr_sched.sv
// Scoreboard bench for mux_rr_sched (BURST=4): requester model drives req/data,
// a monitor checks every accepted beat against hand-ordered expected words.

module tb_mux_rr_sched;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [3:0] in1, in2, in3, in4, in5, in6, in7, in8;
  logic       out_ready;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic [3:0] out;
  logic       out_valid;
  logic       busy;

  int         rem  [8];
  int         cnt  [8];
  int         pcnt [8];
  logic [3:0] base [8];
  logic [6:0] q [$];

  int total;
  int bad;

  mux_rr_sched #(.BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .in4       (in4),
    .in5       (in5),
    .in6       (in6),
    .in7       (in7),
    .in8       (in8),
    .out_ready (out_ready),
    .gnt       (gnt),
    .sel       (sel),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requester model: request while words remain, present base+accepted count
  always_comb begin
    for (int k = 0; k < 8; k++) req[k] = (rem[k] != 0);
  end
  assign in1 = 4'(int'(base[0]) + cnt[0]);
  assign in2 = 4'(int'(base[1]) + cnt[1]);
  assign in3 = 4'(int'(base[2]) + cnt[2]);
  assign in4 = 4'(int'(base[3]) + cnt[3]);
  assign in5 = 4'(int'(base[4]) + cnt[4]);
  assign in6 = 4'(int'(base[5]) + cnt[5]);
  assign in7 = 4'(int'(base[6]) + cnt[6]);
  assign in8 = 4'(int'(base[7]) + cnt[7]);

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: sample acceptance before the edge, advance requesters after it
  task automatic step();
    logic       a;
    logic [7:0] g;
    @(negedge clk);
    a = out_valid & out_ready;
    g = gnt;
    @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) begin
      if (a && g[k]) begin
        rem[k]--;
        cnt[k]++;
      end
    end
    #1;
  endtask

  task automatic add(input int k, input int n);
    rem[k] += n;
    for (int i = 0; i < n; i++) begin
      q.push_back({3'(k), 4'(int'(base[k]) + pcnt[k])});
      pcnt[k]++;
    end
  endtask

  function automatic bit idle_c();
    bit z;
    z = !busy;
    for (int k = 0; k < 8; k++) if (rem[k] != 0) z = 1'b0;
    return z;
  endfunction

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (!idle_c() && n < bound) begin
      step();
      n++;
    end
    total++;
    if (!idle_c()) begin
      bad++;
      $display("FAIL wait_idle: still busy after %0d cycles", bound);
    end
  endtask

  // Monitor: every accepted beat must match the next expected (sel, word)
  initial begin
    logic [6:0] e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_beat: sel=%0d out=%0d with nothing expected", sel, out);
        end else begin
          e = q.pop_front();
          chk("beat_sel", int'(sel), int'(e[6:4]));
          chk("beat_data", int'(out), int'(e[3:0]));
        end
      end
      if (!out_valid) chk("out_zero_when_invalid", int'(out), 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      rem[k]  = 0;
      cnt[k]  = 0;
      pcnt[k] = 0;
      base[k] = 4'(5 * k + 7);
    end

    // Reset state
    repeat (3) step();
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_sel", int'(sel), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_out", int'(out), 0);
    rst = 1'b0;
    step();

    // Single requester 2, words 1..8 over two bursts
    out_ready = 1'b1;
    add(2, 8);
    #1;
    chk("t1_busy_before", int'(busy), 0);
    step();
    chk("t1_gnt", int'(gnt), 8'h04);
    chk("t1_sel", int'(sel), 2);
    chk("t1_busy", int'(busy), 1);
    chk("t1_valid", int'(out_valid), 1);
    chk("t1_out1", int'(out), 1);
    repeat (3) step();
    chk("t1_out4", int'(out), 4);
    chk("t1_gnt4", int'(gnt), 8'h04);
    step();
    chk("t1_gap_gnt", int'(gnt), 0);
    chk("t1_gap_busy", int'(busy), 0);
    chk("t1_gap_valid", int'(out_valid), 0);
    step();
    chk("t1_regnt", int'(gnt), 8'h04);
    chk("t1_regnt_out", int'(out), 5);
    wait_idle(20);

    // Wrap-around: serve 6 (ptr->7), then 8'h44 must pick 2 before 6
    add(6, 4);
    wait_idle(20);
    add(2, 4);
    add(6, 4);
    step();
    chk("wrap_sel", int'(sel), 2);
    chk("wrap_gnt", int'(gnt), 8'h04);
    wait_idle(40);

    // Backpressure: ready low for 5 cycles on the first beat of requester 0
    out_ready = 1'b0;
    add(0, 4);
    step();
    chk("bp_valid", int'(out_valid), 1);
    chk("bp_gnt", int'(gnt), 8'h01);
    chk("bp_out", int'(out), 7);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_hold_valid", int'(out_valid), 1);
      chk("bp_hold_out", int'(out), 7);
      chk("bp_hold_gnt", int'(gnt), 8'h01);
    end
    out_ready = 1'b1;
    repeat (4) step();
    chk("bp_end_busy", int'(busy), 0);
    chk("bp_end_gnt", int'(gnt), 0);

    // Withdrawal: requester 5 leaves after one beat
    add(5, 1);
    step();
    chk("wd_gnt", int'(gnt), 8'h20);
    chk("wd_sel", int'(sel), 5);
    chk("wd_valid", int'(out_valid), 1);
    step();
    chk("wd_drop_valid", int'(out_valid), 0);
    chk("wd_drop_busy", int'(busy), 1);
    step();
    chk("wd_idle_busy", int'(busy), 0);
    chk("wd_idle_gnt", int'(gnt), 0);
    chk("wd_beats", cnt[5], 1);
    add(6, 1);
    add(5, 1);
    step();
    chk("wd_ptr6_sel", int'(sel), 6);
    wait_idle(20);

    // All eight: from ptr 6, nine full bursts with one idle cycle between grants
    add(6, 4);
    add(7, 4);
    for (int k = 0; k < 6; k++) add(k, 4);
    add(6, 4);
    n = 0;
    do begin
      step();
      n++;
    end while (!idle_c() && n < 200);
    chk("rot_cycles", n, 45);

    // Reset mid-burst during the second beat of requester 3
    add(3, 1);
    rem[3] += 3;
    step();
    chk("rb_sel", int'(sel), 3);
    step();
    rst = 1'b1;
    #1;
    chk("rb_gnt", int'(gnt), 0);
    chk("rb_valid", int'(out_valid), 0);
    chk("rb_out", int'(out), 0);
    chk("rb_busy", int'(busy), 0);
    for (int k = 0; k < 8; k++) rem[k] = 0;
    repeat (2) step();
    rst = 1'b0;
    add(0, 1);
    add(7, 1);
    step();
    chk("rb_first_sel", int'(sel), 0);
    chk("rb_first_gnt", int'(gnt), 8'h01);
    wait_idle(20);

    step();
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
